// File: rtl/shared_mult_arbiter.sv
// shared_mult_arbiter: round-robin arbiter feeding two requesters into one pipelined unsigned multiplier,
// with each product returned to its channel by tag.
module shared_mult_arbiter #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               req0_valid_in,
    output logic               req0_ready_out,
    input  logic [WIDTH-1:0]   req0_a_in,
    input  logic [WIDTH-1:0]   req0_b_in,
    input  logic               req1_valid_in,
    output logic               req1_ready_out,
    input  logic [WIDTH-1:0]   req1_a_in,
    input  logic [WIDTH-1:0]   req1_b_in,
    output logic               res0_valid_out,
    output logic [2*WIDTH-1:0] res0_data_out,
    output logic               res1_valid_out,
    output logic [2*WIDTH-1:0] res1_data_out,
    output logic               busy_out
);
    logic                   r_last_grant;
    logic [PIPE_STAGES-1:0] r_v;
    logic [PIPE_STAGES-1:0] r_tag;
    logic [WIDTH-1:0]       r_a [PIPE_STAGES];
    logic [WIDTH-1:0]       r_b [PIPE_STAGES];
    logic [2*WIDTH-1:0]     r_hold0;
    logic [2*WIDTH-1:0]     r_hold1;
    logic [2*WIDTH-1:0]     w_prod;
    logic                   w_g0;
    logic                   w_g1;
    logic                   w_acc;

    always_comb begin
        w_g0   = enable_in && !rst_in && req0_valid_in && (!req1_valid_in || r_last_grant);
        w_g1   = enable_in && !rst_in && req1_valid_in && (!req0_valid_in || !r_last_grant);
        w_acc  = w_g0 || w_g1;
        w_prod = {{WIDTH{1'b0}}, r_a[PIPE_STAGES-1]} * {{WIDTH{1'b0}}, r_b[PIPE_STAGES-1]};
    end

    assign req0_ready_out = w_g0;
    assign req1_ready_out = w_g1;
    assign res0_valid_out = r_v[PIPE_STAGES-1] && !r_tag[PIPE_STAGES-1];
    assign res1_valid_out = r_v[PIPE_STAGES-1] &&  r_tag[PIPE_STAGES-1];
    // The last stage presents the product for its pulse; otherwise the held value is shown.
    assign res0_data_out  = res0_valid_out ? w_prod : r_hold0;
    assign res1_data_out  = res1_valid_out ? w_prod : r_hold1;
    assign busy_out       = |r_v;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_v          <= '0;
            r_last_grant <= 1'b1;
            r_hold0      <= '0;
            r_hold1      <= '0;
        end else begin
            r_v[0]  <= w_acc;
            for (int i = 1; i < PIPE_STAGES; i++) r_v[i] <= r_v[i-1];
            if (w_acc) r_last_grant <= w_g1;
            r_hold0 <= res0_data_out;
            r_hold1 <= res1_data_out;
        end
    end

    // Operand and tag payload is qualified by r_v, so it needs no reset.
    always_ff @(posedge clk_in) begin
        r_tag[0] <= w_g1;
        r_a[0]   <= w_g1 ? req1_a_in : req0_a_in;
        r_b[0]   <= w_g1 ? req1_b_in : req0_b_in;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            r_tag[i] <= r_tag[i-1];
            r_a[i]   <= r_a[i-1];
            r_b[i]   <= r_b[i-1];
        end
    end
endmodule

// File: tb/tb_shared_mult_arbiter.sv
// tb_shared_mult_arbiter: directed self-checking bench for shared_mult_arbiter
// (default depth instance plus a PIPE_STAGES=4 instance).
module tb_shared_mult_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic        v0, v1, rdy0, rdy1, rv0, rv1, busy;
    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] d0, d1;
    logic        p_v0, p_rdy0, p_rdy1, p_rv0, p_rv1, p_busy;
    logic [7:0]  p_a0, p_b0;
    logic [15:0] p_d0, p_d1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_in = ~clk_in;

    shared_mult_arbiter #(.WIDTH(8), .PIPE_STAGES(2)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .req0_valid_in(v0), .req0_ready_out(rdy0), .req0_a_in(a0), .req0_b_in(b0),
        .req1_valid_in(v1), .req1_ready_out(rdy1), .req1_a_in(a1), .req1_b_in(b1),
        .res0_valid_out(rv0), .res0_data_out(d0), .res1_valid_out(rv1), .res1_data_out(d1),
        .busy_out(busy)
    );

    shared_mult_arbiter #(.WIDTH(8), .PIPE_STAGES(4)) u_dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .req0_valid_in(p_v0), .req0_ready_out(p_rdy0), .req0_a_in(p_a0), .req0_b_in(p_b0),
        .req1_valid_in(1'b0), .req1_ready_out(p_rdy1), .req1_a_in(8'h00), .req1_b_in(8'h00),
        .res0_valid_out(p_rv0), .res0_data_out(p_d0), .res1_valid_out(p_rv1), .res1_data_out(p_d1),
        .busy_out(p_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b1; enable_in = 1'b1;
        v0 = 1'b1; a0 = 8'd0; b0 = 8'd0; v1 = 1'b1; a1 = 8'd0; b1 = 8'd0;
        p_v0 = 1'b0; p_a0 = 8'd0; p_b0 = 8'd0;
        repeat (2) cyc();
        #1;
        chk("rst_rdy0", rdy0, 0); chk("rst_rdy1", rdy1, 0); chk("rst_busy", busy, 0);
        chk("rst_rv0", rv0, 0); chk("rst_rv1", rv1, 0); chk("rst_d0", d0, 0); chk("rst_d1", d1, 0);
        chk("rst_p_busy", p_busy, 0);
        // single channel 0 request: 3*5
        cyc(); rst_in = 1'b0; v1 = 1'b0; a0 = 8'd3; b0 = 8'd5; #1;
        chk("t1_rdy0", rdy0, 1); chk("t1_rdy1", rdy1, 0);
        cyc(); v0 = 1'b0; #1;
        chk("t1_rv0_early", rv0, 0); chk("t1_busy", busy, 1);
        cyc(); #1;
        chk("t1_rv0", rv0, 1); chk("t1_d0", d0, 16'd15); chk("t1_rv1", rv1, 0);
        cyc(); #1;
        chk("t1_rv0_off", rv0, 0); chk("t1_d0_hold", d0, 16'd15); chk("t1_busy_off", busy, 0);
        // both valid: last grant was ch0, so ch1 wins first, then alternate
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) begin v0 = 1'b1; a0 = 8'd2; b0 = 8'd7; v1 = 1'b1; a1 = 8'd4; b1 = 8'd9; end
            if (k == 6) begin v0 = 1'b0; v1 = 1'b0; end
            #1;
            if (k < 6) begin
                chk("alt_rdy0", rdy0, k % 2); chk("alt_rdy1", rdy1, (k + 1) % 2);
            end
            if (k >= 2) begin
                chk("alt_rv0", rv0, k % 2); chk("alt_rv1", rv1, (k + 1) % 2);
                chk("alt_data", (k % 2) ? d0 : d1, (k % 2) ? 16'd14 : 16'd36);
            end
        end
        // ch1 all-ones then zero operand
        cyc(); v1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF; #1;
        chk("t3_rdy1", rdy1, 1); chk("t3_rdy0", rdy0, 0);
        cyc(); a1 = 8'h00; #1;
        chk("t3_rdy1_b", rdy1, 1);
        // disable with both valid while two results drain
        cyc(); enable_in = 1'b0; v0 = 1'b1; a0 = 8'd2; b0 = 8'd7; a1 = 8'd4; b1 = 8'd9; #1;
        chk("t4_rdy0_a", rdy0, 0); chk("t4_rdy1_a", rdy1, 0);
        chk("t3_rv1_ff", rv1, 1); chk("t3_d1_ff", d1, 16'hFE01); chk("t4_busy_a", busy, 1);
        cyc(); #1;
        chk("t4_rdy0_b", rdy0, 0); chk("t4_rdy1_b", rdy1, 0);
        chk("t3_rv1_zero", rv1, 1); chk("t3_d1_zero", d1, 16'h0000);
        cyc(); #1;
        chk("t4_rdy0_c", rdy0, 0); chk("t4_rdy1_c", rdy1, 0);
        chk("t4_busy_c", busy, 0); chk("t4_rv1_c", rv1, 0);
        cyc(); enable_in = 1'b1; #1;
        chk("t4_reen_rdy0", rdy0, 1); chk("t4_reen_rdy1", rdy1, 0);
        cyc(); #1;
        chk("t5_rdy1", rdy1, 1); chk("t5_rdy0", rdy0, 0);
        cyc(); #1;
        chk("t5_rdy0_b", rdy0, 1); chk("t5_rv0", rv0, 1); chk("t5_d0", d0, 16'd14);
        // asynchronous reset with two operations in flight
        @(posedge clk_in); #2;
        chk("t5_rv1_pre", rv1, 1); chk("t5_d1_pre", d1, 16'd36); chk("t5_busy_pre", busy, 1);
        rst_in = 1'b1; #1;
        chk("t5_rst_rv0", rv0, 0); chk("t5_rst_rv1", rv1, 0); chk("t5_rst_busy", busy, 0);
        chk("t5_rst_d0", d0, 0); chk("t5_rst_d1", d1, 0);
        chk("t5_rst_rdy0", rdy0, 0); chk("t5_rst_rdy1", rdy1, 0);
        cyc(); rst_in = 1'b0; v0 = 1'b0; v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t5_post_rv0", rv0, 0); chk("t5_post_rv1", rv1, 0); chk("t5_post_busy", busy, 0);
        end
        cyc(); v0 = 1'b1; v1 = 1'b1; #1;
        chk("t5_first_rdy0", rdy0, 1); chk("t5_first_rdy1", rdy1, 0);
        cyc(); v0 = 1'b0; v1 = 1'b0; #1;
        chk("t5_first_busy", busy, 1);
        cyc(); #1;
        chk("t5_first_rv0", rv0, 1); chk("t5_first_d0", d0, 16'd14);
        // four-stage instance: 10*10
        cyc(); p_v0 = 1'b1; p_a0 = 8'd10; p_b0 = 8'd10; #1;
        chk("t6_rdy0", p_rdy0, 1);
        cyc(); p_v0 = 1'b0; #1;
        chk("t6_busy_1", p_busy, 1); chk("t6_rv0_1", p_rv0, 0);
        cyc(); #1;
        chk("t6_busy_2", p_busy, 1); chk("t6_rv0_2", p_rv0, 0);
        cyc(); #1;
        chk("t6_busy_3", p_busy, 1); chk("t6_rv0_3", p_rv0, 0);
        cyc(); #1;
        chk("t6_busy_4", p_busy, 1); chk("t6_rv0_4", p_rv0, 1); chk("t6_d0", p_d0, 16'd100);
        chk("t6_rv1", p_rv1, 0);
        cyc(); #1;
        chk("t6_busy_off", p_busy, 0); chk("t6_rv0_off", p_rv0, 0); chk("t6_d0_hold", p_d0, 16'd100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
